// File: rtl/hd_scan_pkg.sv
// hd_scan_pkg: shared types and sizing helpers for the hd_scan_pipe scan pipeline.
package hd_scan_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD,
        MODE_CAPTURE,
        MODE_SHIFT
    } mode_e;

    function automatic int chain_len(input int width, input int depth);
        return width * depth;
    endfunction

    // Shift counter spans 0..L-1; a one-bit chain still needs a one-bit counter.
    function automatic int cnt_width(input int width, input int depth);
        return (chain_len(width, depth) > 1) ? $clog2(chain_len(width, depth)) : 1;
    endfunction

endpackage

// File: rtl/hd_scan_stage.sv
// hd_scan_stage: one WIDTH-bit pipeline register with capture, hold and serial scan shift.
module hd_scan_stage
    import hd_scan_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             i_sm,
    input  logic             i_en,
    input  logic             i_si,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic             o_so
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_shift;
    mode_e            w_mode;

    assign w_mode = i_sm ? MODE_SHIFT : (i_en ? MODE_CAPTURE : MODE_HOLD);

    // Bit 0 takes the scan input; higher bits take their lower neighbour.
    generate
        if (WIDTH == 1) begin : g_one
            assign w_shift = i_si;
        end else begin : g_multi
            assign w_shift = {r_q[WIDTH-2:0], i_si};
        end
    endgenerate

    always_ff @(posedge CK) begin
        if (!RN)
            r_q <= '0;
        else if (w_mode == MODE_SHIFT)
            r_q <= w_shift;
        else if (w_mode == MODE_CAPTURE)
            r_q <= i_d;
    end

    assign o_q  = r_q;
    assign o_so = r_q[WIDTH-1];

endmodule

// File: rtl/hd_scan_pipe.sv
// hd_scan_pipe: DEPTH-stage scan-register pipeline with D/SD select, valid tracking and
// scan-pass completion pulse.
module hd_scan_pipe
    import hd_scan_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             CK,
    input  logic             RN,
    input  logic [WIDTH-1:0] D,
    input  logic [WIDTH-1:0] SD,
    input  logic             SE,
    input  logic             EN,
    input  logic             VI,
    input  logic             SM,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic             VO,
    output logic             SO,
    output logic             SDONE
);

    localparam int L  = chain_len(WIDTH, DEPTH);
    localparam int CW = cnt_width(WIDTH, DEPTH);
    localparam logic [CW-1:0] LAST = CW'(L - 1);

    logic [WIDTH-1:0] w_q [DEPTH];
    logic [DEPTH-1:0] w_so;
    logic [WIDTH-1:0] w_d0;
    logic [DEPTH-1:0] r_valid;
    logic [CW-1:0]    r_cnt;
    logic             r_sdone;

    assign w_d0 = SE ? SD : D;

    // Stage k captures stage k-1 and scans from its tail bit; stage 0 is fed from outside.
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] w_d;
        logic             w_si;
        if (k == 0) begin : g_head
            assign w_d  = w_d0;
            assign w_si = SI;
        end else begin : g_body
            assign w_d  = w_q[k-1];
            assign w_si = w_so[k-1];
        end
        hd_scan_stage #(.WIDTH(WIDTH)) u_stage (
            .CK   (CK),
            .RN   (RN),
            .i_sm (SM),
            .i_en (EN),
            .i_si (w_si),
            .i_d  (w_d),
            .o_q  (w_q[k]),
            .o_so (w_so[k])
        );
    end

    // Scanned contents are not functional data, so any shift invalidates the pipeline.
    always_ff @(posedge CK) begin
        if (!RN)
            r_valid <= '0;
        else if (SM)
            r_valid <= '0;
        else if (EN)
            r_valid <= DEPTH'({r_valid, VI});
    end

    always_ff @(posedge CK) begin
        if (!RN) begin
            r_cnt   <= '0;
            r_sdone <= 1'b0;
        end else begin
            r_sdone <= SM && (r_cnt == LAST);
            r_cnt   <= (!SM || r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign Q     = w_q[DEPTH-1];
    assign VO    = r_valid[DEPTH-1];
    assign SO    = w_so[DEPTH-1];
    assign SDONE = r_sdone;

endmodule

// File: tb/tb_hd_scan_pipe.sv
// tb_hd_scan_pipe: directed scoreboard bench for hd_scan_pipe (WIDTH=4, DEPTH=2).
module tb_hd_scan_pipe;

    typedef struct packed {
        logic [3:0] q;
        logic       vo;
        logic       so;
        logic       sd;
        logic [3:0] m;
    } exp_t;

    logic       CK = 1'b0;
    logic       RN = 1'b0;
    logic [3:0] D  = '0;
    logic [3:0] SD = '0;
    logic       SE = 1'b0;
    logic       EN = 1'b0;
    logic       VI = 1'b0;
    logic       SM = 1'b0;
    logic       SI = 1'b0;
    logic [3:0] Q;
    logic       VO;
    logic       SO;
    logic       SDONE;

    exp_t  exp_q [$];
    string name_q [$];
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 CK = ~CK;

    hd_scan_pipe #(.WIDTH(4), .DEPTH(2)) dut (
        .CK    (CK),
        .RN    (RN),
        .D     (D),
        .SD    (SD),
        .SE    (SE),
        .EN    (EN),
        .VI    (VI),
        .SM    (SM),
        .SI    (SI),
        .Q     (Q),
        .VO    (VO),
        .SO    (SO),
        .SDONE (SDONE)
    );

    task automatic cmp(input string nm, input string fld, input logic [3:0] act, input logic [3:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s %s: got %h expected %h", nm, fld, act, want);
        end
    endtask

    // Monitor: one expectation per driven cycle, checked just after the edge it describes.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge CK);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e.m[3]) cmp(nm, "Q", Q, e.q);
                if (e.m[2]) cmp(nm, "VO", {3'b0, VO}, {3'b0, e.vo});
                if (e.m[1]) cmp(nm, "SO", {3'b0, SO}, {3'b0, e.so});
                if (e.m[0]) cmp(nm, "SDONE", {3'b0, SDONE}, {3'b0, e.sd});
            end
        end
    end

    task automatic step(input logic rn, input logic sm, input logic si, input logic en,
                        input logic se, input logic vi, input logic [3:0] d, input logic [3:0] sd,
                        input logic [3:0] m, input logic [3:0] eq, input logic evo,
                        input logic eso, input logic esd, input string nm);
        exp_t e;
        @(negedge CK);
        RN = rn; SM = sm; SI = si; EN = en; SE = se; VI = vi; D = d; SD = sd;
        e.q = eq; e.vo = evo; e.so = eso; e.sd = esd; e.m = m;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic shift(input logic si, input logic eso, input logic esd, input string nm);
        step(1'b1, 1'b1, si, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 4'b0111, 4'h0, 1'b0, eso, esd, nm);
    endtask

    initial begin
        logic [7:0] seq;
        logic [7:0] orig;
        seq  = 8'b1011_0010;
        orig = 8'b1100_0000;
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'h9, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, "reset_a");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h7, 4'h2, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, "reset_b");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, "cap1");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h5, 4'h0, 4'hF, 4'hA, 1'b1, 1'b1, 1'b0, "cap2");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 4'h5, 1'b0, 1'b0, 1'b0, "cap3");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'hC, 4'h3, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, "sel");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hC, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, "hold");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'hC, 4'h0, 4'hF, 4'h3, 1'b1, 1'b0, 1'b0, "sel_out");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 4'hC, 1'b0, 1'b1, 1'b0, "d_late");
        // Chain now holds stage1=C, stage0=0, i.e. 1100_0000 from tail to head.
        for (int i = 0; i < 7; i++)
            shift(seq[7-i], orig[6-i], 1'b0, "scan_in");
        step(1'b1, 1'b1, seq[0], 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 4'hB, 1'b0, seq[7], 1'b1, "scan_load");
        for (int i = 0; i < 7; i++)
            shift(1'b0, seq[6-i], 1'b0, "scan_out");
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1, "scan_done2");
        for (int i = 0; i < 5; i++)
            shift(1'b0, 1'b0, 1'b0, "abort_a");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, "abort_gap");
        for (int i = 0; i < 7; i++)
            shift(1'b0, 1'b0, 1'b0, "abort_b");
        shift(1'b0, 1'b0, 1'b1, "abort_done");
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, "pulse_end");
        for (int i = 0; i < 3; i++)
            shift(1'b1, 1'b0, 1'b0, "pre_rst");
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, "rst_mid");
        for (int i = 0; i < 7; i++)
            shift(1'b0, 1'b0, 1'b0, "rst_post");
        shift(1'b0, 1'b0, 1'b1, "rst_post_done");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'h6, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, "recap1");
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h9, 4'h0, 4'hF, 4'h6, 1'b1, 1'b0, 1'b0, "recap2");
        @(negedge CK);
        EN = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge CK);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
